ex_alu_unit: RTL and testbench

- Execute-stage datapath of the MIPS pipeline. Directly downstream of the ALU control decoder: consumes its 3-bit ALUoperation plus the two ID/EX operands, and produces a registered result and zero flag for the EX/MEM register.
- Single-cycle ops complete with 1-cycle latency.
- mult runs on an iterative shift-add engine and stalls the pipeline through a stall output.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/seq_multiplier.sv | 78 +++++++
 rtl/ex_alu_unit.sv | 130 +++++++++++++
 tb/tb_ex_alu_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: ALU operation codes and execute-stage state type shared by the EX datapath.
// Revision: 1.0
`default_nettype none

package mips_pkg;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_MULT = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  typedef enum logic [0:0] {
    EX_IDLE = 1'b0,
    EX_MULT = 1'b1
  } ex_state_t;

endpackage

`default_nettype wire

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative signed shift-add multiplier, one partial product per cycle.
// Revision: 1.0
`default_nettype none

module seq_multiplier #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = WIDTH,
  parameter int PW          = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [PW-1:0]    o_product
);

  localparam int CW = $clog2(MULT_CYCLES) + 1;

  logic            r_busy;
  logic            r_sign;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_mcand;
  logic [WIDTH:0]  r_mplier;
  logic [PW-1:0]   r_acc;

  logic [WIDTH:0]  w_a_ext;
  logic [WIDTH:0]  w_b_ext;
  logic [WIDTH:0]  w_a_mag;
  logic [WIDTH:0]  w_b_mag;
  logic [PW-1:0]   w_acc_nxt;

  // Magnitudes are one bit wider so the most-negative operand negates cleanly.
  assign w_a_ext   = {i_a[WIDTH-1], i_a};
  assign w_b_ext   = {i_b[WIDTH-1], i_b};
  assign w_a_mag   = i_a[WIDTH-1] ? -w_a_ext : w_a_ext;
  assign w_b_mag   = i_b[WIDTH-1] ? -w_b_ext : w_b_ext;

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_done    = r_busy && !i_flush && (r_cnt == CW'(MULT_CYCLES - 1));
  assign o_product = r_sign ? -w_acc_nxt : w_acc_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_sign   <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_flush) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_sign   <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= PW'(w_a_mag);
      r_mplier <= w_b_mag;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (o_done) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ex_alu_unit.sv
// ex_alu_unit: MIPS EX-stage ALU with registered result/zero and a stalling iterative multiply.
// Optional macro EX_ALU_HILO_EN adds hi/lo outputs holding the full signed product. Revision: 1.0
`default_nettype none

module ex_alu_unit
  import mips_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             flush,
  input  logic [2:0]       ALUoperation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             out_valid,
  output logic             stall
`ifdef EX_ALU_HILO_EN
  ,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`endif
);

`ifdef EX_ALU_HILO_EN
  localparam int PW = 2 * WIDTH;
`else
  localparam int PW = WIDTH;
`endif

  ex_state_t        r_state;
  ex_state_t        w_state_nxt;

  logic             w_accept;
  logic             w_start;
  logic             w_single;
  logic             w_mul_done;
  logic             w_mul_fin;
  logic [PW-1:0]    w_product;
  logic [WIDTH-1:0] w_alu;

  seq_multiplier #(
    .WIDTH       (WIDTH),
    .MULT_CYCLES (MULT_CYCLES),
    .PW          (PW)
  ) u_mult (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_start),
    .i_flush   (flush),
    .i_a       (a),
    .i_b       (b),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= EX_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EX_IDLE: if (w_start) w_state_nxt = EX_MULT;
      EX_MULT: if (flush || w_mul_done) w_state_nxt = EX_IDLE;
      default: w_state_nxt = EX_IDLE;
    endcase
  end

  // Stall is raised in the acceptance cycle itself so upstream holds ID/EX.
  always_comb begin
    w_accept  = (r_state == EX_IDLE) && in_valid && !flush;
    w_start   = w_accept && (ALUoperation == ALU_MULT);
    w_single  = w_accept && (ALUoperation != ALU_MULT);
    w_mul_fin = (r_state == EX_MULT) && w_mul_done;
    stall     = (r_state == EX_MULT) ||
                ((r_state == EX_IDLE) && in_valid && (ALUoperation == ALU_MULT));
  end

  always_comb begin
    w_alu = '0;
    case (ALUoperation)
      ALU_ADD: w_alu = a + b;
      ALU_SUB: w_alu = a - b;
      ALU_AND: w_alu = a & b;
      ALU_OR:  w_alu = a | b;
      ALU_XOR: w_alu = a ^ b;
      ALU_SLT: w_alu = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
    end else if (w_single) begin
      result    <= w_alu;
      zero      <= (w_alu == '0);
      out_valid <= 1'b1;
    end else if (w_mul_fin) begin
      result    <= w_product[WIDTH-1:0];
      zero      <= (w_product[WIDTH-1:0] == '0);
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

`ifdef EX_ALU_HILO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (w_mul_fin) begin
      hi <= w_product[PW-1:WIDTH];
      lo <= w_product[WIDTH-1:0];
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_alu_unit.sv
// tb_ex_alu_unit: scoreboard bench for ex_alu_unit, directed cases plus randomized ops vs. an arithmetic model.
// Revision: 1.0
`default_nettype none

module tb_ex_alu_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          flush = 1'b0;
  logic [2:0]    op = 3'b000;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [W-1:0]  result;
  logic          zero;
  logic          out_valid;
  logic          stall;
`ifdef EX_ALU_HILO_EN
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
`endif

  ex_alu_unit #(.WIDTH(W), .MULT_CYCLES(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .flush        (flush),
    .ALUoperation (op),
    .a            (a),
    .b            (b),
    .result       (result),
    .zero         (zero),
    .out_valid    (out_valid),
    .stall        (stall)
`ifdef EX_ALU_HILO_EN
    ,
    .hi           (hi),
    .lo           (lo)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t         exp_q[$];
  int           n_chk = 0;
  int           n_fail = 0;
  logic [W-1:0] mdl_hi = '0;
  logic [W-1:0] mdl_lo = '0;
  logic [W-1:0] mdl_last = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain two's complement arithmetic on the architectural values.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e;
    longint p;
    e.hi = mdl_hi;
    e.lo = mdl_lo;
    case (o)
      3'b010:  e.res = x + y;
      3'b110:  e.res = x - y;
      3'b000:  e.res = x & y;
      3'b001:  e.res = x | y;
      3'b101:  e.res = x ^ y;
      3'b111:  e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'b011: begin
        p = longint'($signed(x)) * longint'($signed(y));
        e.res = p[31:0];
        e.hi  = p[63:32];
        e.lo  = p[31:0];
      end
      default: e.res = '0;
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  task automatic push_exp(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e = model(o, x, y);
    mdl_hi = e.hi;
    mdl_lo = e.lo;
    mdl_last = e.res;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got result %h expected no output at %0t", result, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", 64'(result), 64'(e.res));
        chk("zero", 64'(zero), 64'(e.z));
`ifdef EX_ALU_HILO_EN
        chk("hi", 64'(hi), 64'(e.hi));
        chk("lo", 64'(lo), 64'(e.lo));
`endif
      end
    end
  end

  // Issue one single-cycle op; caller is just after a rising edge.
  task automatic issue_single(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = 1'b1; op = o; a = x; b = y;
    push_exp(o, x, y);
    @(negedge clk);
    chk("stall_single", 64'(stall), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic mult_accept(input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = 1'b1; op = 3'b011; a = x; b = y;
    @(negedge clk);
    chk("stall_accept", 64'(stall), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
  endtask

  task automatic issue_mult(input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    push_exp(3'b011, x, y);
    mult_accept(x, y);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (out_valid) begin
        chk("mult_latency", 64'(n), 64'd33);
        chk("stall_at_out_valid", 64'(stall), 64'd0);
        break;
      end
      if (stall !== 1'b1) chk("stall_during_mult", 64'(stall), 64'd1);
      if (n > 40) begin
        chk("mult_timeout", 64'(n), 64'd33);
        void'(exp_q.pop_back());
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_zero", 64'(zero), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    issue_single(3'b010, 32'd7, 32'd8);
    issue_single(3'b110, 32'd5, 32'd5);
    issue_single(3'b111, 32'hFFFF_FFFF, 32'd1);
    issue_single(3'b101, 32'hF0, 32'hFF);
    issue_single(3'b100, 32'd5, 32'd9);
    issue_single(3'b010, 32'd1, 32'd1);

    issue_mult(32'hFFFF_FFFD, 32'd7);
    issue_mult(32'h8000_0000, 32'd2);
    issue_mult(32'h8000_0000, 32'd1);
    issue_single(3'b010, 32'd100, 32'd1);

    // Reset in the middle of a multiply.
    mult_accept(32'd1234, 32'd5678);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mdl_hi = '0; mdl_lo = '0; mdl_last = '0;
    @(negedge clk);
    chk("rst_mid_result", 64'(result), 64'd0);
    chk("rst_mid_zero", 64'(zero), 64'd1);
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    issue_single(3'b010, 32'd2, 32'd3);

    // Flush at iteration 5 of a multiply.
    mult_accept(32'd6, 32'd6);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_stall_idle", 64'(stall), 64'd0);
    chk("flush_result_held", 64'(result), 64'(mdl_last));
    @(posedge clk); #1;
    issue_single(3'b000, 32'hC, 32'hA);

    // Flush in IDLE kills the same-cycle input.
    in_valid = 1'b1; op = 3'b010; a = 32'd9; b = 32'd9; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      logic [2:0]   ro;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ro = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      if (ro == 3'b011) issue_mult(ra, rb);
      else issue_single(ro, ra, rb);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
